// File: rtl/vga_timing_gen.sv
// Pixel-clock video timing generator: programmable h/v counters driving sync, blank, gate and eol/eof pulses.
// Latency: every output is registered one clock after the counter state that produced it.
// Backpressure: none, free-running while ctrl_ven=1. Optional csync output is enabled by VGA_TGEN_CSYNC_EN.
module vga_timing_gen #(
    parameter int HW = 16,
    parameter int SW = 8
) (
    input  logic          clk_pclk_i,
    input  logic          rst_nreset_i,
    input  logic          ctrl_ven,
    input  logic          ctrl_hsyncl,
    input  logic          ctrl_vsyncl,
    input  logic          ctrl_csyncl,
    input  logic          ctrl_blankl,
    input  logic [SW-1:0] thsync,
    input  logic [SW-1:0] thgdel,
    input  logic [HW-1:0] thgate,
    input  logic [HW-1:0] thlen,
    input  logic [SW-1:0] tvsync,
    input  logic [SW-1:0] tvgdel,
    input  logic [HW-1:0] tvgate,
    input  logic [HW-1:0] tvlen,
    output logic          eoh_o,
    output logic          eov_o,
    output logic          gate_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          csync_o,
    output logic          blank_o
);

    localparam int EW = HW + 1;

    logic [SW-1:0] thsync_s, thgdel_s, tvsync_s, tvgdel_s;
    logic [HW-1:0] thgate_s, thlen_s, tvgate_s, tvlen_s;
    logic [HW-1:0] hcnt, vcnt;

    logic          h_end, v_end, frame_end, shadow_load;
    logic [EW-1:0] hcnt_e, vcnt_e;
    logic [EW-1:0] hs_lim, hg_lo, hg_hi;
    logic [EW-1:0] vs_lim, vg_lo, vg_hi;
    logic          hs, vs, hg, vg, gate;

    assign h_end       = (hcnt == thlen_s);
    assign v_end       = (vcnt == tvlen_s);
    assign frame_end   = h_end & v_end;
    assign shadow_load = ~ctrl_ven | frame_end;

    // Timing inputs are only sampled between frames so a frame is never torn.
    always_ff @(posedge clk_pclk_i or negedge rst_nreset_i) begin
        if (!rst_nreset_i) begin
            thsync_s <= '0;
            thgdel_s <= '0;
            thgate_s <= '0;
            thlen_s  <= '0;
            tvsync_s <= '0;
            tvgdel_s <= '0;
            tvgate_s <= '0;
            tvlen_s  <= '0;
        end else if (shadow_load) begin
            thsync_s <= thsync;
            thgdel_s <= thgdel;
            thgate_s <= thgate;
            thlen_s  <= thlen;
            tvsync_s <= tvsync;
            tvgdel_s <= tvgdel;
            tvgate_s <= tvgate;
            tvlen_s  <= tvlen;
        end
    end

    always_ff @(posedge clk_pclk_i or negedge rst_nreset_i) begin
        if (!rst_nreset_i) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (!ctrl_ven) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_end) begin
            hcnt <= '0;
            vcnt <= v_end ? '0 : vcnt + HW'(1);
        end else begin
            hcnt <= hcnt + HW'(1);
        end
    end

    // One extra bit keeps the porch/gate window sums from wrapping.
    assign hcnt_e = EW'(hcnt);
    assign vcnt_e = EW'(vcnt);
    assign hs_lim = EW'(thsync_s);
    assign vs_lim = EW'(tvsync_s);
    assign hg_lo  = EW'(thsync_s) + EW'(thgdel_s) + EW'(2);
    assign hg_hi  = hg_lo + EW'(thgate_s);
    assign vg_lo  = EW'(tvsync_s) + EW'(tvgdel_s) + EW'(2);
    assign vg_hi  = vg_lo + EW'(tvgate_s);

    assign hs   = ctrl_ven & (hcnt_e <= hs_lim);
    assign vs   = ctrl_ven & (vcnt_e <= vs_lim);
    assign hg   = (hcnt_e >= hg_lo) & (hcnt_e <= hg_hi);
    assign vg   = (vcnt_e >= vg_lo) & (vcnt_e <= vg_hi);
    assign gate = ctrl_ven & hg & vg;

    always_ff @(posedge clk_pclk_i or negedge rst_nreset_i) begin
        if (!rst_nreset_i) begin
            eoh_o   <= 1'b0;
            eov_o   <= 1'b0;
            gate_o  <= 1'b0;
            hsync_o <= 1'b0;
            vsync_o <= 1'b0;
            blank_o <= 1'b0;
        end else begin
            eoh_o   <= ctrl_ven & h_end;
            eov_o   <= ctrl_ven & frame_end;
            gate_o  <= gate;
            hsync_o <= hs ^ ctrl_hsyncl;
            vsync_o <= vs ^ ctrl_vsyncl;
            blank_o <= ~gate ^ ctrl_blankl;
        end
    end

`ifdef VGA_TGEN_CSYNC_EN
    always_ff @(posedge clk_pclk_i or negedge rst_nreset_i) begin
        if (!rst_nreset_i) begin
            csync_o <= 1'b0;
        end else begin
            csync_o <= (hs | vs) ^ ctrl_csyncl;
        end
    end
`else
    logic unused_csyncl;
    assign unused_csyncl = ctrl_csyncl;
    assign csync_o       = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen against a frame-position reference model.
module tb_vga_timing_gen;

    logic        clk_pclk_i = 1'b0;
    logic        rst_nreset_i = 1'b0;
    logic        ctrl_ven = 1'b0;
    logic        ctrl_hsyncl = 1'b0, ctrl_vsyncl = 1'b0, ctrl_csyncl = 1'b0, ctrl_blankl = 1'b0;
    logic [7:0]  thsync = '0, thgdel = '0, tvsync = '0, tvgdel = '0;
    logic [15:0] thgate = '0, thlen = '0, tvgate = '0, tvlen = '0;
    logic        eoh_o, eov_o, gate_o, hsync_o, vsync_o, csync_o, blank_o;

    vga_timing_gen #(.HW(16), .SW(8)) dut (
        .clk_pclk_i(clk_pclk_i), .rst_nreset_i(rst_nreset_i), .ctrl_ven(ctrl_ven),
        .ctrl_hsyncl(ctrl_hsyncl), .ctrl_vsyncl(ctrl_vsyncl),
        .ctrl_csyncl(ctrl_csyncl), .ctrl_blankl(ctrl_blankl),
        .thsync(thsync), .thgdel(thgdel), .thgate(thgate), .thlen(thlen),
        .tvsync(tvsync), .tvgdel(tvgdel), .tvgate(tvgate), .tvlen(tvlen),
        .eoh_o(eoh_o), .eov_o(eov_o), .gate_o(gate_o), .hsync_o(hsync_o),
        .vsync_o(vsync_o), .csync_o(csync_o), .blank_o(blank_o)
    );

    always #5 clk_pclk_i = ~clk_pclk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: position within the current frame plus the frame's latched timing set.
    int m_pos = 0;
    int s_ths = 0, s_thg = 0, s_thgate = 0, s_thlen = 0;
    int s_tvs = 0, s_tvg = 0, s_tvgate = 0, s_tvlen = 0;
    bit e_eoh = 0, e_eov = 0, e_gate = 0, e_hs = 0, e_vs = 0, e_cs = 0, e_bl = 0;
    int cnt_eoh = 0, cnt_eov = 0, cnt_gate = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic load_shadow();
        s_ths = thsync; s_thg = thgdel; s_thgate = thgate; s_thlen = thlen;
        s_tvs = tvsync; s_tvg = tvgdel; s_tvgate = tvgate; s_tvlen = tvlen;
    endtask

    task automatic model_reset();
        m_pos = 0;
        s_ths = 0; s_thg = 0; s_thgate = 0; s_thlen = 0;
        s_tvs = 0; s_tvg = 0; s_tvgate = 0; s_tvlen = 0;
    endtask

    task automatic model_step();
        int  h, v, line_len;
        bit  hs, vs, gt, eh, ev;
        hs = 0; vs = 0; gt = 0; eh = 0; ev = 0;
        if (!ctrl_ven) begin
            m_pos = 0;
            load_shadow();
        end else begin
            line_len = s_thlen + 1;
            h  = m_pos % line_len;
            v  = m_pos / line_len;
            hs = (h <= s_ths);
            vs = (v <= s_tvs);
            gt = (h >= s_ths + s_thg + 2) && (h <= s_ths + s_thg + s_thgate + 2) &&
                 (v >= s_tvs + s_tvg + 2) && (v <= s_tvs + s_tvg + s_tvgate + 2);
            eh = (h == s_thlen);
            ev = eh && (v == s_tvlen);
            m_pos++;
            if (ev) begin
                m_pos = 0;
                load_shadow();
            end
        end
        e_eoh  = eh;
        e_eov  = ev;
        e_gate = gt;
        e_hs   = hs ^ ctrl_hsyncl;
        e_vs   = vs ^ ctrl_vsyncl;
`ifdef VGA_TGEN_CSYNC_EN
        e_cs   = (hs | vs) ^ ctrl_csyncl;
`else
        e_cs   = 1'b0;
`endif
        e_bl   = (!gt) ^ ctrl_blankl;
    endtask

    // Inputs already set for the coming edge; compare on the following falling edge.
    task automatic tick();
        model_step();
        @(negedge clk_pclk_i);
        chk("eoh",   eoh_o,   e_eoh);
        chk("eov",   eov_o,   e_eov);
        chk("gate",  gate_o,  e_gate);
        chk("hsync", hsync_o, e_hs);
        chk("vsync", vsync_o, e_vs);
        chk("csync", csync_o, e_cs);
        chk("blank", blank_o, e_bl);
        cnt_eoh  += int'(eoh_o);
        cnt_eov  += int'(eov_o);
        cnt_gate += int'(gate_o);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_eoh"},   eoh_o,   0);
        chk({tag, "_eov"},   eov_o,   0);
        chk({tag, "_gate"},  gate_o,  0);
        chk({tag, "_hsync"}, hsync_o, 0);
        chk({tag, "_vsync"}, vsync_o, 0);
        chk({tag, "_csync"}, csync_o, 0);
        chk({tag, "_blank"}, blank_o, 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic sync_to_frame(input string tag);
        int budget;
        budget = 2000;
        e_eov = 0;
        while (!(e_eov && eov_o) && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic set_h(input int s, input int d, input int g, input int l);
        thsync = 8'(s); thgdel = 8'(d); thgate = 16'(g); thlen = 16'(l);
    endtask

    task automatic set_v(input int s, input int d, input int g, input int l);
        tvsync = 8'(s); tvgdel = 8'(d); tvgate = 16'(g); tvlen = 16'(l);
    endtask

    task automatic async_reset();
        rst_nreset_i = 1'b0;
        #1;
        check_all_zero("rst");
        model_reset();
        @(negedge clk_pclk_i);
        check_all_zero("rst_hold");
        rst_nreset_i = 1'b1;
    endtask

    initial begin
        int budget, rs, rd, rg;
        // Reset and idle
        #3;
        check_all_zero("init");
        @(negedge clk_pclk_i);
        rst_nreset_i = 1'b1;
        ctrl_hsyncl  = 1'b1;
        tick();
        chk("idle_hsync_pol", hsync_o, 1);
        ctrl_hsyncl = 1'b0;
        run(3);

        // Horizontal and frame timing
        set_h(1, 1, 3, 9);
        set_v(0, 0, 1, 4);
        tick();
        ctrl_ven = 1'b1;
        sync_to_frame("frame0");
        cnt_eoh = 0; cnt_eov = 0; cnt_gate = 0;
        run(50);
        chk("frame_eoh_count",  cnt_eoh,  5);
        chk("frame_eov_count",  cnt_eov,  1);
        chk("frame_gate_count", cnt_gate, 8);

        // Polarity flip
        ctrl_hsyncl = 1'b1; ctrl_vsyncl = 1'b1; ctrl_csyncl = 1'b1; ctrl_blankl = 1'b1;
        run(50);

        // Shadowing: change gate width mid-frame
        sync_to_frame("shadow_sync");
        cnt_gate = 0;
        run(20);
        thgate = 16'd5;
        run(30);
        chk("shadow_old_gate", cnt_gate, 8);
        cnt_gate = 0;
        run(50);
        chk("shadow_new_gate", cnt_gate, 12);
        thgate = 16'd3;
        sync_to_frame("ven_sync");

        // ven drop at hcnt=5, then reassert
        budget = 100;
        while ((m_pos % (s_thlen + 1)) != 5 && budget > 0) begin
            tick();
            budget--;
        end
        ctrl_ven = 1'b0;
        cnt_eoh = 0;
        run(4);
        chk("ven_drop_eoh", cnt_eoh, 0);
        chk("ven_drop_gate", gate_o, 0);
        ctrl_ven = 1'b1;
        budget = 0;
        e_eoh = 0;
        while (!(e_eoh && eoh_o) && budget < 100) begin
            tick();
            budget++;
        end
        chk("ven_reassert_eoh_delay", budget, 10);

        // Mid-frame reset
        run(17);
        async_reset();
        run(30);

        // Randomized phase
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                rs = $urandom_range(0, 3); rd = $urandom_range(0, 3); rg = $urandom_range(0, 6);
                set_h(rs, rd, rg, rs + rd + rg + $urandom_range(0, 6));
                rs = $urandom_range(0, 2); rd = $urandom_range(0, 2); rg = $urandom_range(0, 3);
                set_v(rs, rd, rg, rs + rd + rg + $urandom_range(0, 4));
            end
            if ($urandom_range(0, 4) == 0) begin
                ctrl_hsyncl = 1'($urandom); ctrl_vsyncl = 1'($urandom);
                ctrl_csyncl = 1'($urandom); ctrl_blankl = 1'($urandom);
            end
            if ($urandom_range(0, 5) == 0) ctrl_ven = ~ctrl_ven;
            else if (!ctrl_ven && $urandom_range(0, 1) == 0) ctrl_ven = 1'b1;
            if ($urandom_range(0, 19) == 0) async_reset();
            run($urandom_range(5, 120));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
